haze_src_arbiter: RTL

- Time-multiplexes one shared haze filter pipeline (down-sampled median filter, then rank/average stage) between CH_NUM laser channels.
- Each channel offers down-sampled haze candidate samples. The block buffers one sample per channel, grants round-robin, and enforces a minimum spacing between samples sent downstream.
- Tags each granted sample with its channel index so downstream haze state can be demultiplexed.

---
 rtl/haze_src_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/haze_src_arbiter.sv
// Round-robin source arbiter feeding one shared haze filter pipeline from CH_NUM laser channels.
// One holding register per channel, newest-wins overwrite accounting and a minimum spacing between grants.
module haze_src_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM     = 4,
  parameter int CH_ID_W    = 2,
  parameter int MIN_GAP    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [CH_NUM-1:0]            ch_en_i,
  input  logic [CH_NUM-1:0]            src_vld_i,
  input  logic [CH_NUM*DATA_WIDTH-1:0] src_data_i,
  input  logic                         clear_i,
  output logic                         arb_vld_o,
  output logic [DATA_WIDTH-1:0]        arb_data_o,
  output logic [CH_ID_W-1:0]           arb_ch_o,
  output logic                         busy_o,
  output logic [CH_NUM-1:0]            ovf_o,
  output logic [15:0]                  drop_cnt_o
);

  localparam int GAP_W = 4;
  localparam int CNT_W = 4;

  logic [DATA_WIDTH-1:0] r_hold_data [CH_NUM];
  logic [CH_NUM-1:0]     r_hold_full;
  logic [CH_ID_W-1:0]    r_rr_ptr;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_arb_vld;
  logic [DATA_WIDTH-1:0] r_arb_data;
  logic [CH_ID_W-1:0]    r_arb_ch;
  logic                  r_busy;
  logic [CH_NUM-1:0]     r_ovf;
  logic [15:0]           r_drop_cnt;

  logic [CH_NUM-1:0]     w_cap;
  logic [CH_NUM-1:0]     w_req;
  logic [CH_NUM-1:0]     w_grant_oh;
  logic [CH_NUM-1:0]     w_ovw;
  logic [CH_NUM-1:0]     w_full_nxt;
  logic                  w_grant_any;
  logic [CH_ID_W-1:0]    w_grant_idx;
  logic [CH_ID_W-1:0]    w_next_ptr;
  logic [CH_ID_W:0]      w_idx;
  logic [CNT_W-1:0]      w_drop_inc;
  logic [16:0]           w_drop_sum;

  assign w_cap = src_vld_i & ch_en_i & {CH_NUM{enable_i}};
  assign w_req = r_hold_full & ch_en_i;

  // Walk the search order backwards so the last hit is the first channel at or after r_rr_ptr.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    if (enable_i && (r_gap_cnt == '0)) begin
      for (int k = CH_NUM - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_rr_ptr} + (CH_ID_W + 1)'(k);
        if (w_idx >= (CH_ID_W + 1)'(CH_NUM)) begin
          w_idx = w_idx - (CH_ID_W + 1)'(CH_NUM);
        end
        if (w_req[w_idx[CH_ID_W-1:0]]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_idx[CH_ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_next_ptr = '0;
    if (w_grant_idx != CH_ID_W'(CH_NUM - 1)) begin
      w_next_ptr = w_grant_idx + 1'b1;
    end
  end

  always_comb begin
    w_grant_oh = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_grant_oh[c] = w_grant_any && (w_grant_idx == CH_ID_W'(c));
    end
  end

  // A capture only counts as a drop when the old sample is not leaving in the same cycle.
  assign w_ovw = w_cap & r_hold_full & ~w_grant_oh;

  always_comb begin
    w_drop_inc = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      w_drop_inc = w_drop_inc + CNT_W'(w_ovw[c]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);

  always_comb begin
    w_full_nxt = r_hold_full;
    for (int c = 0; c < CH_NUM; c++) begin
      if (!enable_i || !ch_en_i[c]) begin
        w_full_nxt[c] = 1'b0;
      end else if (w_cap[c]) begin
        w_full_nxt[c] = 1'b1;
      end else if (w_grant_oh[c]) begin
        w_full_nxt[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_full <= '0;
      r_busy      <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        r_hold_data[c] <= '0;
      end
    end else begin
      r_hold_full <= w_full_nxt;
      r_busy      <= |w_full_nxt;
      for (int c = 0; c < CH_NUM; c++) begin
        if (w_cap[c]) begin
          r_hold_data[c] <= src_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_gap_cnt  <= '0;
      r_arb_vld  <= 1'b0;
      r_arb_data <= '0;
      r_arb_ch   <= '0;
    end else begin
      r_arb_vld <= w_grant_any;
      if (w_grant_any) begin
        r_arb_data <= r_hold_data[w_grant_idx];
        r_arb_ch   <= w_grant_idx;
      end
      if (!enable_i) begin
        r_rr_ptr  <= '0;
        r_gap_cnt <= '0;
      end else if (w_grant_any) begin
        r_rr_ptr  <= w_next_ptr;
        r_gap_cnt <= GAP_W'(MIN_GAP - 1);
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // Clear wins over any overwrite recorded in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_ovf      <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ovf <= r_ovf | w_ovw;
      if (w_drop_sum[16]) begin
        r_drop_cnt <= 16'hFFFF;
      end else begin
        r_drop_cnt <= w_drop_sum[15:0];
      end
    end
  end

  assign arb_vld_o  = r_arb_vld;
  assign arb_data_o = r_arb_data;
  assign arb_ch_o   = r_arb_ch;
  assign busy_o     = r_busy;
  assign ovf_o      = r_ovf;
  assign drop_cnt_o = r_drop_cnt;

endmodule
